// File: rtl/de_regfile_scoreboard_pkg.sv
// Shared widths, writeback bus layout and CSR window helper for the decode-stage
// register file and scoreboard.
package de_regfile_scoreboard_pkg;

    localparam int unsigned DBITS      = 32;
    localparam int unsigned REGWORDS   = 32;
    localparam int unsigned REGNOBITS  = 5;
    localparam int unsigned CSRNOBITS  = 12;
    localparam int unsigned CSRWINBITS = 2;
    localparam int unsigned CSR_WORDS  = 4;
    localparam int unsigned SB_CNTBITS = 2;

    localparam logic [CSRNOBITS-1:0] CSR_BASE = 12'h340;

    localparam int unsigned from_WB_to_DE_WIDTH = 1 + REGNOBITS + DBITS + CSRNOBITS + 1;

    typedef struct packed {
        logic                 wr_reg;
        logic [REGNOBITS-1:0] wregno;
        logic [DBITS-1:0]     regval;
        logic [CSRNOBITS-1:0] wcsrno;
        logic                 wr_csr;
    } wb_bus_t;

    typedef logic [SB_CNTBITS-1:0] sb_cnt_t;

    // True when a CSR index falls inside the 4-entry window at CSR_BASE.
    function automatic logic csr_in_window(input logic [CSRNOBITS-1:0] no);
        return no[CSRNOBITS-1:CSRWINBITS] == CSR_BASE[CSRNOBITS-1:CSRWINBITS];
    endfunction

endpackage

// File: rtl/de_regfile_scoreboard_sb_counter.sv
// Per-register pending-write counter: 2-bit up/down, holds at either end and
// pulses err_c on an overflowing increment or underflowing decrement.
module sb_counter
    import de_regfile_scoreboard_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    inc,
    input  logic    dec,
    output sb_cnt_t cnt,
    output logic    err_c
);

    sb_cnt_t cnt_q;
    sb_cnt_t cnt_d;

    // Coincident inc and dec cancel; a lone step past either end holds and errors.
    always_comb begin
        cnt_d = cnt_q;
        err_c = 1'b0;
        if (inc && !dec) begin
            if (cnt_q == '1) begin
                err_c = 1'b1;
            end else begin
                cnt_d = cnt_q + SB_CNTBITS'(1);
            end
        end else if (dec && !inc) begin
            if (cnt_q == '0) begin
                err_c = 1'b1;
            end else begin
                cnt_d = cnt_q - SB_CNTBITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/de_regfile_scoreboard.sv
// Decode-stage GPR file, CSR window and RAW scoreboard fed by the writeback bus;
// reads bypass the same-cycle writeback value.
module de_regfile_scoreboard
    import de_regfile_scoreboard_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic [from_WB_to_DE_WIDTH-1:0] from_WB_to_DE,
    input  logic                           issue_valid,
    input  logic                           issue_wr_reg,
    input  logic [REGNOBITS-1:0]           issue_rd,
    input  logic [REGNOBITS-1:0]           rs1_no,
    input  logic [REGNOBITS-1:0]           rs2_no,
    input  logic                           use_rs1,
    input  logic                           use_rs2,
    output logic [DBITS-1:0]               rs1_val,
    output logic [DBITS-1:0]               rs2_val,
    input  logic [CSRNOBITS-1:0]           csr_rd_no,
    output logic [DBITS-1:0]               csr_rd_val,
    output logic                           stall,
    output logic                           sb_err
);

    wb_bus_t wb;
    logic    gpr_we;
    logic    csr_we;
    logic    inc_any;

    assign wb      = wb_bus_t'(from_WB_to_DE);
    assign gpr_we  = wb.wr_reg && (wb.wregno != '0);
    assign csr_we  = wb.wr_csr && csr_in_window(wb.wcsrno);
    assign inc_any = issue_valid && issue_wr_reg && (issue_rd != '0);

    logic [DBITS-1:0] regs_q [REGWORDS];
    logic [DBITS-1:0] regs_d [REGWORDS];
    logic [DBITS-1:0] csr_q  [CSR_WORDS];
    logic [DBITS-1:0] csr_d  [CSR_WORDS];
    logic             sb_err_q;
    logic             sb_err_d;

    // Storage updates; x0 is never written so it stays at its reset value of 0.
    always_comb begin
        regs_d = regs_q;
        csr_d  = csr_q;
        if (gpr_we) begin
            regs_d[wb.wregno] = wb.regval;
        end
        if (csr_we) begin
            csr_d[wb.wcsrno[CSRWINBITS-1:0]] = wb.regval;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < REGWORDS; i++) begin
                regs_q[i] <= '0;
            end
            for (int unsigned i = 0; i < CSR_WORDS; i++) begin
                csr_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
            csr_q  <= csr_d;
        end
    end

    logic [REGWORDS-1:1] inc_vec;
    logic [REGWORDS-1:1] dec_vec;
    logic [REGWORDS-1:1] err_vec;
    sb_cnt_t             cnt_w [REGWORDS];

    assign cnt_w[0] = '0;

    for (genvar r = 1; r < REGWORDS; r++) begin : g_sb
        assign inc_vec[r] = inc_any && (issue_rd == REGNOBITS'(r));
        assign dec_vec[r] = gpr_we && (wb.wregno == REGNOBITS'(r));

        sb_counter u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (inc_vec[r]),
            .dec   (dec_vec[r]),
            .cnt   (cnt_w[r]),
            .err_c (err_vec[r])
        );
    end

    assign sb_err_d = sb_err_q | (|err_vec);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_err_q <= 1'b0;
        end else begin
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

    sb_cnt_t eff1;
    sb_cnt_t eff2;

    // Reads with writeback bypass; a producer retiring this cycle no longer counts as pending.
    always_comb begin
        rs1_val    = '0;
        rs2_val    = '0;
        csr_rd_val = '0;
        if (rs1_no != '0) begin
            rs1_val = (gpr_we && (wb.wregno == rs1_no)) ? wb.regval : regs_q[rs1_no];
        end
        if (rs2_no != '0) begin
            rs2_val = (gpr_we && (wb.wregno == rs2_no)) ? wb.regval : regs_q[rs2_no];
        end
        if (csr_in_window(csr_rd_no)) begin
            csr_rd_val = (csr_we && (wb.wcsrno == csr_rd_no)) ? wb.regval
                                                              : csr_q[csr_rd_no[CSRWINBITS-1:0]];
        end
        eff1  = cnt_w[rs1_no] - SB_CNTBITS'(gpr_we && (wb.wregno == rs1_no));
        eff2  = cnt_w[rs2_no] - SB_CNTBITS'(gpr_we && (wb.wregno == rs2_no));
        stall = (use_rs1 && (eff1 != '0)) || (use_rs2 && (eff2 != '0));
    end

endmodule

// File: tb/tb_de_regfile_scoreboard.sv
// Randomized and directed bench for de_regfile_scoreboard against an
// array/counter reference model of register, CSR and pending-write state.
module tb_de_regfile_scoreboard;

    typedef struct packed {
        logic        iv;
        logic        iwr;
        logic [4:0]  ird;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        u1;
        logic        u2;
        logic [11:0] crd;
        logic        wr;
        logic [4:0]  wno;
        logic [31:0] val;
        logic [11:0] cno;
        logic        wcs;
    } stim_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [50:0] from_wb;
    logic        issue_valid;
    logic        issue_wr_reg;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_no;
    logic [4:0]  rs2_no;
    logic        use_rs1;
    logic        use_rs2;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [11:0] csr_rd_no;
    logic [31:0] csr_rd_val;
    logic        stall;
    logic        sb_err;

    always #5 clk = ~clk;

    de_regfile_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .from_WB_to_DE (from_wb),
        .issue_valid   (issue_valid),
        .issue_wr_reg  (issue_wr_reg),
        .issue_rd      (issue_rd),
        .rs1_no        (rs1_no),
        .rs2_no        (rs2_no),
        .use_rs1       (use_rs1),
        .use_rs2       (use_rs2),
        .rs1_val       (rs1_val),
        .rs2_val       (rs2_val),
        .csr_rd_no     (csr_rd_no),
        .csr_rd_val    (csr_rd_val),
        .stall         (stall),
        .sb_err        (sb_err)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_cnt  [32];
    logic [31:0] m_regs [32];
    logic [31:0] m_csr  [4];
    logic        m_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_cnt[i]  = 0;
            m_regs[i] = '0;
        end
        for (int i = 0; i < 4; i++) m_csr[i] = '0;
        m_err = 1'b0;
    endfunction

    function automatic logic in_win(input logic [11:0] no);
        return (no >= 12'h340) && (no <= 12'h343);
    endfunction

    function automatic logic [31:0] exp_gpr(input stim_t s, input logic [4:0] no);
        if (no == 5'd0) return '0;
        if (s.wr && s.wno == no) return s.val;
        return m_regs[no];
    endfunction

    function automatic logic [31:0] exp_csr(input stim_t s, input logic [11:0] no);
        if (!in_win(no)) return '0;
        if (s.wcs && s.cno == no) return s.val;
        return m_csr[no - 12'h340];
    endfunction

    function automatic logic pending(input stim_t s, input logic [4:0] no);
        int e;
        e = m_cnt[no] - ((s.wr && s.wno != 5'd0 && s.wno == no) ? 1 : 0);
        return e != 0;
    endfunction

    function automatic void model_commit(input stim_t s);
        for (int r = 1; r < 32; r++) begin
            logic inc_r;
            logic dec_r;
            inc_r = s.iv && s.iwr && (int'(s.ird) == r);
            dec_r = s.wr && (int'(s.wno) == r);
            if (inc_r && !dec_r) begin
                if (m_cnt[r] == 3) m_err = 1'b1;
                else m_cnt[r] = m_cnt[r] + 1;
            end else if (dec_r && !inc_r) begin
                if (m_cnt[r] == 0) m_err = 1'b1;
                else m_cnt[r] = m_cnt[r] - 1;
            end
        end
        if (s.wr && s.wno != 5'd0) m_regs[s.wno] = s.val;
        if (s.wcs && in_win(s.cno)) m_csr[s.cno - 12'h340] = s.val;
    endfunction

    // Drive one cycle, check all outputs mid-cycle, then commit the model at the edge.
    task automatic step(input stim_t s);
        issue_valid  = s.iv;
        issue_wr_reg = s.iwr;
        issue_rd     = s.ird;
        rs1_no       = s.r1;
        rs2_no       = s.r2;
        use_rs1      = s.u1;
        use_rs2      = s.u2;
        csr_rd_no    = s.crd;
        from_wb      = {s.wr, s.wno, s.val, s.cno, s.wcs};
        @(negedge clk);
        check_eq("rs1_val", rs1_val, exp_gpr(s, s.r1));
        check_eq("rs2_val", rs2_val, exp_gpr(s, s.r2));
        check_eq("csr_rd_val", csr_rd_val, exp_csr(s, s.crd));
        check_eq("stall", 32'(stall),
                 32'((s.u1 && pending(s, s.r1)) || (s.u2 && pending(s, s.r2))));
        check_eq("sb_err", 32'(sb_err), 32'(m_err));
        @(posedge clk);
        model_commit(s);
        #1;
    endtask

    stim_t s;

    initial begin
        reset = 1'b0;
        s = '0;
        issue_valid = 1'b0; issue_wr_reg = 1'b0; issue_rd = '0;
        use_rs1 = 1'b1; use_rs2 = 1'b1; rs1_no = 5'd5; rs2_no = 5'd0;
        csr_rd_no = 12'h342; from_wb = '0;
        model_reset();
        #12;
        check_eq("reset_rs1", rs1_val, 32'h0);
        check_eq("reset_rs2", rs2_val, 32'h0);
        check_eq("reset_csr", csr_rd_val, 32'h0);
        check_eq("reset_stall", 32'(stall), 32'h0);
        check_eq("reset_sb_err", 32'(sb_err), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Write x7 with bypass, then read it from storage.
        s = '0; s.iv = 1; s.iwr = 1; s.ird = 5'd7; step(s);
        s = '0; s.wr = 1; s.wno = 5'd7; s.val = 32'hDEADBEEF; s.r1 = 5'd7; s.u1 = 1; step(s);
        s = '0; s.r1 = 5'd7; s.u1 = 1; step(s);
        check_eq("x7_storage_direct", 32'hDEADBEEF, m_regs[7]);

        // RAW on x3 resolved by same-cycle writeback.
        s = '0; s.iv = 1; s.iwr = 1; s.ird = 5'd3; step(s);
        s = '0; s.r1 = 5'd3; s.u1 = 1; step(s);
        s = '0; s.wr = 1; s.wno = 5'd3; s.val = 32'h55; s.r1 = 5'd3; s.u1 = 1; step(s);

        // CSR window hit and miss.
        s = '0; s.wcs = 1; s.cno = 12'h342; s.val = 32'hA5; s.crd = 12'h342; step(s);
        s = '0; s.crd = 12'h342; step(s);
        s = '0; s.wcs = 1; s.cno = 12'h300; s.val = 32'h77; s.crd = 12'h300; step(s);
        s = '0; s.crd = 12'h300; step(s);

        // x0 is inert for issue, writeback and reads.
        s = '0; s.iv = 1; s.iwr = 1; s.ird = 5'd0; s.wr = 1; s.wno = 5'd0; s.val = 32'hFF;
        s.r1 = 5'd0; s.u1 = 1; step(s);
        s = '0; s.r1 = 5'd0; s.u1 = 1; step(s);

        // Saturation of x4: coincident inc/dec at 3 is clean, a lone 4th issue errors.
        for (int i = 0; i < 3; i++) begin
            s = '0; s.iv = 1; s.iwr = 1; s.ird = 5'd4; step(s);
        end
        s = '0; s.iv = 1; s.iwr = 1; s.ird = 5'd4; s.wr = 1; s.wno = 5'd4; s.val = 32'h4;
        s.r1 = 5'd4; s.u1 = 1; step(s);
        s = '0; s.iv = 1; s.iwr = 1; s.ird = 5'd4; s.r1 = 5'd4; s.u1 = 1; step(s);
        for (int i = 0; i < 3; i++) begin
            s = '0; s.wr = 1; s.wno = 5'd4; s.val = 32'(i + 16); s.r2 = 5'd4; s.u2 = 1; step(s);
        end
        s = '0; s.r2 = 5'd4; s.u2 = 1; step(s);
        check_eq("sb_err_sticky", 32'(sb_err), 32'h1);

        // Mid-stream asynchronous reset clears pending counts, storage and error.
        s = '0; s.iv = 1; s.iwr = 1; s.ird = 5'd9; step(s);
        issue_valid = 1'b0; from_wb = '0;
        rs1_no = 5'd7; rs2_no = 5'd9; use_rs1 = 1'b1; use_rs2 = 1'b1; csr_rd_no = 12'h342;
        reset = 1'b0;
        #2;
        check_eq("midrst_rs1", rs1_val, 32'h0);
        check_eq("midrst_rs2", rs2_val, 32'h0);
        check_eq("midrst_csr", csr_rd_val, 32'h0);
        check_eq("midrst_stall", 32'(stall), 32'h0);
        check_eq("midrst_sb_err", 32'(sb_err), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        s = '0; s.r1 = 5'd9; s.u1 = 1; s.r2 = 5'd7; s.u2 = 1; s.crd = 12'h342; step(s);

        // Random legal traffic: no overflow or underflow, so sb_err must stay low.
        for (int i = 0; i < 600; i++) begin
            s = '0;
            s.wno = 5'($urandom_range(1, 31));
            if (m_cnt[s.wno] > 0 && $urandom_range(0, 3) != 0) begin
                s.wr  = 1'b1;
                s.val = $urandom;
            end else if ($urandom_range(0, 7) == 0) begin
                s.wr  = 1'b1;
                s.wno = 5'd0;
                s.val = $urandom;
            end
            s.ird = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            s.iwr = 1'($urandom_range(0, 3) != 0);
            s.iv  = 1'($urandom_range(0, 1));
            if (s.iwr && s.ird != 5'd0 && m_cnt[s.ird] == 3 && !(s.wr && s.wno == s.ird)) s.iv = 1'b0;
            s.r1  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : s.wno;
            s.r2  = 5'($urandom_range(0, 31));
            s.u1  = 1'($urandom_range(0, 1));
            s.u2  = 1'($urandom_range(0, 1));
            s.wcs = 1'($urandom_range(0, 1));
            s.cno = 12'h33E + 12'($urandom_range(0, 7));
            s.crd = ($urandom_range(0, 1) == 0) ? s.cno : 12'h33E + 12'($urandom_range(0, 7));
            step(s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
